// File: rtl/fight_pkg.sv
// Shared types and constants for the fight health manager.
// Optional build macro used by the top: HEALTH_REGEN_EN.
package fight_pkg;

  localparam int unsigned HEALTH_W = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FIGHT = 2'd1,
    KO    = 2'd2
  } state_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  // Damage with saturation at zero
  function automatic logic [HEALTH_W-1:0] sat_sub(input logic [HEALTH_W-1:0] h,
                                                  input logic [HEALTH_W-1:0] d);
    return (h > d) ? (h - d) : '0;
  endfunction

endpackage

// File: rtl/hit_debounce.sv
// Frame-sampled rising-edge detector with per-attacker cooldown.
// accept is a single-cycle pulse on the frame tick that lands a new punch.
module hit_debounce
  import fight_pkg::*;
#(
  parameter int unsigned COOLDOWN_FRAMES = 20
) (
  input  logic Clk,
  input  logic Reset,
  input  logic frame_tick,
  input  logic hit_in,
  input  logic clear,
  output logic accept
);

  localparam int unsigned CW = $clog2(COOLDOWN_FRAMES + 1);

  logic          hist;
  logic [CW-1:0] cooldown;
  logic          rise;
  logic          expired;

  // Cooldown of 1 expires on this tick, so an edge landing here is accepted
  always_comb begin
    rise    = hit_in & ~hist;
    expired = (cooldown <= CW'(1));
    accept  = frame_tick & rise & expired & ~clear;
  end

  // History tracks every tick; cooldown loads on accept and counts down per tick
  always_ff @(posedge Clk) begin
    if (Reset) begin
      hist     <= 1'b0;
      cooldown <= '0;
    end else begin
      if (frame_tick) hist <= hit_in;
      if (clear)
        cooldown <= '0;
      else if (accept)
        cooldown <= CW'(COOLDOWN_FRAMES);
      else if (frame_tick && (cooldown != '0))
        cooldown <= cooldown - CW'(1);
    end
  end

endmodule

// File: rtl/health_manager.sv
// Per-player health, round state and winner driven by frame-sampled hits.
// Define HEALTH_REGEN_EN to enable slow health regeneration during a fight.
module health_manager
  import fight_pkg::*;
#(
  parameter logic [HEALTH_W-1:0] MAX_HEALTH      = 10'd100,
  parameter logic [HEALTH_W-1:0] DAMAGE          = 10'd10,
  parameter int unsigned         COOLDOWN_FRAMES = 20
`ifdef HEALTH_REGEN_EN
  , parameter int unsigned       REGEN_FRAMES    = 60
`endif
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                frame_tick,
  input  logic                hit1,
  input  logic                hit2,
  input  logic                round_start,
  output logic [HEALTH_W-1:0] health1,
  output logic [HEALTH_W-1:0] health2,
  output logic                game_over,
  output logic [1:0]          winner,
  output logic                fight_active
);

  state_t              state, state_d;
  logic [HEALTH_W-1:0] health1_d, health2_d;
  logic [1:0]          winner_d;
  logic                game_over_d, fight_active_d;
  logic                acc1, acc2;
  logic                clear;
  logic                regen1, regen2;

  // Cooldowns only run inside a fight; a restart wipes them
  assign clear = round_start | (state != FIGHT);

  hit_debounce #(.COOLDOWN_FRAMES(COOLDOWN_FRAMES)) u_deb1 (
    .Clk        (Clk),
    .Reset      (Reset),
    .frame_tick (frame_tick),
    .hit_in     (hit1),
    .clear      (clear),
    .accept     (acc1)
  );

  hit_debounce #(.COOLDOWN_FRAMES(COOLDOWN_FRAMES)) u_deb2 (
    .Clk        (Clk),
    .Reset      (Reset),
    .frame_tick (frame_tick),
    .hit_in     (hit2),
    .clear      (clear),
    .accept     (acc2)
  );

`ifdef HEALTH_REGEN_EN
  localparam int unsigned RW = $clog2(REGEN_FRAMES + 1);

  logic [RW-1:0] regen_cnt1, regen_cnt2;
  logic          regen_run;

  // Regen fires on the tick the counter completes, unless that player is hit
  always_comb begin
    regen_run = frame_tick & (state == FIGHT) & ~round_start;
    regen1    = regen_run & ~acc2 & (regen_cnt1 == RW'(REGEN_FRAMES - 1));
    regen2    = regen_run & ~acc1 & (regen_cnt2 == RW'(REGEN_FRAMES - 1));
  end

  // Frames-since-hit counters, held at zero outside a fight
  always_ff @(posedge Clk) begin
    if (Reset) begin
      regen_cnt1 <= '0;
      regen_cnt2 <= '0;
    end else if ((state != FIGHT) || round_start) begin
      regen_cnt1 <= '0;
      regen_cnt2 <= '0;
    end else if (frame_tick) begin
      regen_cnt1 <= (acc2 || regen1) ? '0 : regen_cnt1 + RW'(1);
      regen_cnt2 <= (acc1 || regen2) ? '0 : regen_cnt2 + RW'(1);
    end
  end
`else
  // No regeneration in this build
  always_comb begin
    regen1 = 1'b0;
    regen2 = 1'b0;
  end
`endif

  // Round state machine plus next health and winner
  always_comb begin
    state_d   = state;
    health1_d = health1;
    health2_d = health2;
    winner_d  = winner;
    case (state)
      IDLE: begin
        health1_d = MAX_HEALTH;
        health2_d = MAX_HEALTH;
        winner_d  = WIN_NONE;
        if (round_start) state_d = FIGHT;
      end
      FIGHT: begin
        if (round_start) begin
          health1_d = MAX_HEALTH;
          health2_d = MAX_HEALTH;
          winner_d  = WIN_NONE;
        end else if (frame_tick) begin
          if (acc2)
            health1_d = sat_sub(health1, DAMAGE);
          else if (regen1 && (health1 < MAX_HEALTH))
            health1_d = health1 + HEALTH_W'(1);
          if (acc1)
            health2_d = sat_sub(health2, DAMAGE);
          else if (regen2 && (health2 < MAX_HEALTH))
            health2_d = health2 + HEALTH_W'(1);
          if ((health1_d == '0) || (health2_d == '0)) begin
            state_d = KO;
            if ((health1_d == '0) && (health2_d == '0)) winner_d = WIN_DRAW;
            else if (health1_d == '0)                    winner_d = WIN_P2;
            else                                         winner_d = WIN_P1;
          end
        end
      end
      KO: begin
        if (round_start) begin
          state_d   = FIGHT;
          health1_d = MAX_HEALTH;
          health2_d = MAX_HEALTH;
          winner_d  = WIN_NONE;
        end
      end
      default: state_d = IDLE;
    endcase
    game_over_d    = (state_d == KO);
    fight_active_d = (state_d == FIGHT);
  end

  // State and registered outputs
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state        <= IDLE;
      health1      <= MAX_HEALTH;
      health2      <= MAX_HEALTH;
      winner       <= WIN_NONE;
      game_over    <= 1'b0;
      fight_active <= 1'b0;
    end else begin
      state        <= state_d;
      health1      <= health1_d;
      health2      <= health2_d;
      winner       <= winner_d;
      game_over    <= game_over_d;
      fight_active <= fight_active_d;
    end
  end

endmodule

// File: tb/tb_health_manager.sv
// Self-checking bench for health_manager: directed round scenarios plus
// random traffic compared against a tick-index based behavioural model.
module tb_health_manager;

  localparam int MAXH  = 100;
  localparam int DMG   = 10;
  localparam int COOL  = 20;
  localparam int REGEN = 60;

  logic       Clk;
  logic       Reset;
  logic       frame_tick;
  logic       hit1;
  logic       hit2;
  logic       round_start;
  logic [9:0] health1;
  logic [9:0] health2;
  logic       game_over;
  logic [1:0] winner;
  logic       fight_active;

  health_manager dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .frame_tick   (frame_tick),
    .hit1         (hit1),
    .hit2         (hit2),
    .round_start  (round_start),
    .health1      (health1),
    .health2      (health2),
    .game_over    (game_over),
    .winner       (winner),
    .fight_active (fight_active)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 idle, 1 fighting, 2 knocked out
  int m_phase;
  int m_h1, m_h2, m_win;
  bit m_prev1, m_prev2;
  int ticks;
  int last_acc1, last_acc2;   // tick index of last accepted punch, -1 = none
  int last_evt1, last_evt2;   // tick index of last hit taken / regen / start

  task automatic model_step(input bit rst, input bit rs, input bit tk,
                            input bit a, input bit b);
    bit fighting, acc1, acc2;
    if (rst) begin
      m_phase = 0; m_h1 = MAXH; m_h2 = MAXH; m_win = 0;
      m_prev1 = 0; m_prev2 = 0;
      last_acc1 = -1; last_acc2 = -1;
      return;
    end
    fighting = (m_phase == 1);
    acc1 = 0;
    acc2 = 0;
    if (tk) begin
      ticks++;
      if (fighting && !rs) begin
        acc1 = a && !m_prev1 && (last_acc1 < 0 || ticks - last_acc1 >= COOL);
        acc2 = b && !m_prev2 && (last_acc2 < 0 || ticks - last_acc2 >= COOL);
      end
      m_prev1 = a;
      m_prev2 = b;
    end
    if (rs) begin
      m_phase = 1; m_h1 = MAXH; m_h2 = MAXH; m_win = 0;
      last_acc1 = -1; last_acc2 = -1;
      last_evt1 = ticks; last_evt2 = ticks;
    end else if (fighting && tk) begin
      if (acc1) last_acc1 = ticks;
      if (acc2) last_acc2 = ticks;
      if (acc2) begin
        m_h1 = (m_h1 > DMG) ? m_h1 - DMG : 0;
        last_evt1 = ticks;
      end
`ifdef HEALTH_REGEN_EN
      else if (ticks - last_evt1 == REGEN) begin
        m_h1 = (m_h1 + 1 > MAXH) ? MAXH : m_h1 + 1;
        last_evt1 = ticks;
      end
`endif
      if (acc1) begin
        m_h2 = (m_h2 > DMG) ? m_h2 - DMG : 0;
        last_evt2 = ticks;
      end
`ifdef HEALTH_REGEN_EN
      else if (ticks - last_evt2 == REGEN) begin
        m_h2 = (m_h2 + 1 > MAXH) ? MAXH : m_h2 + 1;
        last_evt2 = ticks;
      end
`endif
      if (m_h1 == 0 || m_h2 == 0) begin
        m_phase = 2;
        m_win = (m_h1 == 0 && m_h2 == 0) ? 3 : (m_h1 == 0) ? 2 : 1;
      end
    end
    if (m_phase != 1) begin
      last_acc1 = -1;
      last_acc2 = -1;
    end
  endtask

  // One clock: drive, let the edge happen, advance model, compare everything
  task automatic cyc(input bit rst, input bit rs, input bit tk,
                     input bit a, input bit b);
    Reset = rst; round_start = rs; frame_tick = tk; hit1 = a; hit2 = b;
    @(posedge Clk);
    model_step(rst, rs, tk, a, b);
    #1;
    chk("health1", int'(health1), m_h1);
    chk("health2", int'(health2), m_h2);
    chk("winner", int'(winner), m_win);
    chk("game_over", int'(game_over), int'(m_phase == 2));
    chk("fight_active", int'(fight_active), int'(m_phase == 1));
  endtask

  task automatic frame(input bit a, input bit b);
    cyc(1'b0, 1'b0, 1'b1, a, b);
    cyc(1'b0, 1'b0, 1'b0, a, b);
    cyc(1'b0, 1'b0, 1'b0, a, b);
  endtask

  task automatic start_round();
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    ticks = 0;
    last_evt1 = 0; last_evt2 = 0;
    Reset = 1'b1; round_start = 1'b0; frame_tick = 1'b0; hit1 = 1'b0; hit2 = 1'b0;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset_h1", int'(health1), 100);
    chk("reset_win", int'(winner), 0);
    chk("reset_fa", int'(fight_active), 0);

    // Hits in IDLE do nothing
    frame(1'b1, 1'b1);
    frame(1'b0, 1'b0);
    chk("idle_h2", int'(health2), 100);

    // Held punch counts once
    start_round();
    for (int i = 0; i < 5; i++) frame(1'b1, 1'b0);
    chk("held_h2", int'(health2), 90);
    chk("held_h1", int'(health1), 100);
    chk("held_win", int'(winner), 0);
    frame(1'b0, 1'b0);

    // Cooldown: ticks 0, 3, 20 -> 0 and 20 accepted
    start_round();
    for (int i = 0; i < 26; i++) frame(i == 0 || i == 3 || i == 20, 1'b0);
    chk("cool_h2", int'(health2), 80);

    // Ten hits to KO, then further hits ignored
    start_round();
    for (int i = 0; i < 226; i++) frame(i % 25 == 0, 1'b0);
    chk("ko_h2", int'(health2), 0);
    chk("ko_go", int'(game_over), 1);
    chk("ko_win", int'(winner), 1);
    chk("ko_fa", int'(fight_active), 0);
    for (int i = 0; i < 4; i++) frame(i % 2 == 0, i % 2 == 0);
    chk("ko_frozen_h1", int'(health1), 100);

    // Restart from KO
    start_round();
    chk("restart_h2", int'(health2), 100);
    chk("restart_go", int'(game_over), 0);
    chk("restart_fa", int'(fight_active), 1);

    // Simultaneous final hits -> draw
    for (int i = 0; i < 226; i++) frame(i % 25 == 0, i % 25 == 0);
    chk("draw_h1", int'(health1), 0);
    chk("draw_win", int'(winner), 3);

    // Round start coincident with a rising edge discards the hit
    start_round();
    frame(1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("rs_wins_h2", int'(health2), 100);

    // Reset mid-fight
    frame(1'b0, 1'b1);
    frame(1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("midreset_h1", int'(health1), 100);
    chk("midreset_fa", int'(fight_active), 0);

    // Regeneration window
    start_round();
    for (int i = 0; i <= 120; i++) frame(1'b0, i == 0);
`ifdef HEALTH_REGEN_EN
    chk("regen_h1", int'(health1), 92);
`else
    chk("regen_h1", int'(health1), 90);
`endif
    start_round();
    for (int i = 0; i <= 60; i++) frame(1'b0, i == 0 || i == 60);
    chk("regen_hit_h1", int'(health1), 80);

    // Random traffic against the model
    begin
      bit a = 0, b = 0;
      start_round();
      for (int i = 0; i < 4000; i++) begin
        bit tk, rs, rst;
        tk  = ($urandom_range(0, 2) == 0);
        rs  = ($urandom_range(0, 299) == 0);
        rst = ($urandom_range(0, 1499) == 0);
        if ($urandom_range(0, 3) == 0) a = ~a;
        if ($urandom_range(0, 3) == 0) b = ~b;
        cyc(rst, rs, tk, a, b);
        if (m_phase != 1 && $urandom_range(0, 39) == 0) start_round();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
